// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared encodings for the J/K excitation transmitter
package jk_pkg;

    localparam int ENC_MIN   = 0;
    localparam int ENC_TOG   = 1;
    localparam int ENC_FORCE = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/jk_excite_tx_if.sv
// rtl/jk_excite_tx_if.sv - parallel word handshake into the J/K transmitter
interface jk_excite_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jk_excite_enc.sv
// rtl/jk_excite_enc.sv - maps (present q, wanted q) to a J/K excitation pair
module jk_excite_enc
    import jk_pkg::*;
#(
    parameter int ENC_MODE = ENC_MIN
) (
    input  logic p,
    input  logic d,
    output logic j,
    output logic k
);

    always_comb begin
        j = 1'b0;
        k = 1'b0;
        case (ENC_MODE)
            ENC_TOG: begin
                j = p ^ d;
                k = p ^ d;
            end
            ENC_FORCE: begin
                j = d;
                k = ~d;
            end
            default: begin
                j = ~p & d;
                k = p & ~d;
            end
        endcase
    end

endmodule

// File: rtl/jk_excite_tx.sv
// rtl/jk_excite_tx.sv - serialises words as J/K excitation and checks the returned q
module jk_excite_tx
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ENC_MODE  = ENC_MIN,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    jk_excite_tx_if.slave    word,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    input  logic             clear_err,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  cnt;
    logic             q_pred;
    logic             exp1, exp2, v1, v2;
    logic             d_bit, j_enc, k_enc, accept, check_fail;

    assign d_bit      = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    assign accept     = (state == ST_IDLE) && word.in_valid;
    assign check_fail = v2 && (q_fb != exp2);
    assign word.in_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    jk_excite_enc #(.ENC_MODE(ENC_MODE)) u_enc (
        .p(q_pred),
        .d(d_bit),
        .j(j_enc),
        .k(k_enc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_nxt = ST_DRAIN;
            ST_DRAIN: if (cnt == BC_W'(1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            q_pred    <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            exp1      <= 1'b0;
            exp2      <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
            mismatch <= check_fail;
            j        <= 1'b0;
            k        <= 1'b0;
            // expected q trails the excitation by two edges (flop, then its output)
            v1       <= (state == ST_SHIFT);
            exp1     <= d_bit;
            v2       <= v1;
            exp2     <= exp1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= word.in_data;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    j      <= j_enc;
                    k      <= k_enc;
                    q_pred <= d_bit;
                    shreg  <= (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    cnt    <= (cnt == LAST_BIT) ? '0 : cnt + BC_W'(1);
                end
                ST_DRAIN: cnt <= cnt + BC_W'(1);
                default: ;
            endcase
            if (clear_err)
                err_count <= '0;
            else if (check_fail && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_jk_excite_tx.sv
// tb/tb_jk_excite_tx.sv - scoreboard bench for jk_excite_tx in all three encodings
module tb_jk_excite_tx;

    typedef struct {
        logic [1:0] jk;
        logic       q;
        logic       mm;
        logic       dn;
        logic       rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in_valid;
    logic [7:0] in_data [3];
    logic [2:0] clear_err;
    logic [2:0] force0;
    logic [2:0] jv, kv, busy, done, mm, rdy, qv;
    logic [7:0] errc [3];

    exp_t sb[$];
    bit   mp [3];
    bit   mq [3];
    int   errm [3];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gd
        jk_excite_tx_if #(.WIDTH(8)) w ();
        logic qff, qfb, jl, kl, bl, dl, ml;
        logic [7:0] el;

        assign w.in_valid = in_valid[g];
        assign w.in_data  = in_data[g];
        assign rdy[g]     = w.in_ready;
        assign qfb        = force0[g] ? 1'b0 : qff;
        assign jv[g] = jl;
        assign kv[g] = kl;
        assign busy[g] = bl;
        assign done[g] = dl;
        assign mm[g] = ml;
        assign qv[g] = qff;
        assign errc[g] = el;

        jk_excite_tx #(.WIDTH(8), .ENC_MODE(g), .LSB_FIRST(0), .CNT_W(8)) dut (
            .clk(clk), .reset(reset), .word(w.slave), .j(jl), .k(kl), .q_fb(qfb),
            .clear_err(clear_err[g]), .busy(bl), .done(dl), .mismatch(ml), .err_count(el)
        );

        // downstream jk_ff
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) qff <= 1'b0;
            else begin
                case ({jl, kl})
                    2'b10: qff <= 1'b1;
                    2'b01: qff <= 1'b0;
                    2'b11: qff <= ~qff;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit ff_next(bit q, bit [1:0] jk);
        case (jk)
            2'b10: return 1'b1;
            2'b01: return 1'b0;
            2'b11: return ~q;
            default: return q;
        endcase
    endfunction

    function automatic bit [1:0] enc_model(int mode, bit p, bit d);
        if (mode == 1) return (p != d) ? 2'b11 : 2'b00;
        if (mode == 2) return d ? 2'b10 : 2'b01;
        if (p == d) return 2'b00;
        return d ? 2'b10 : 2'b01;
    endfunction

    task automatic push_word(input int g, input logic [7:0] data);
        bit [1:0] jkprev = 2'b00;
        bit q = mq[g];
        bit qh [11];
        bit fb, b;
        exp_t e;
        qh[0] = q;
        for (int c = 1; c <= 10; c++) begin
            q = ff_next(q, jkprev);
            qh[c] = q;
            e.jk = 2'b00;
            if (c <= 8) begin
                b = data[8 - c];
                e.jk = enc_model(g, mp[g], b);
                mp[g] = b;
            end
            e.q  = q;
            e.mm = 1'b0;
            if (c >= 3) begin
                fb = force0[g] ? 1'b0 : qh[c-1];
                e.mm = (fb != data[10 - c]);
                if (e.mm && errm[g] < 255) errm[g]++;
            end
            e.dn  = (c == 10);
            e.rdy = (c >= 10);
            jkprev = e.jk;
            sb.push_back(e);
        end
        mq[g] = q;
    endtask

    task automatic run_word(input int g, input logic [7:0] data, input bit hold, input logic [7:0] nxt);
        exp_t e;
        check("ready_before_accept", rdy[g], 1);
        in_valid[g] = 1'b1;
        in_data[g]  = data;
        push_word(g, data);
        @(posedge clk); #1;
        if (hold) in_data[g] = nxt;
        else in_valid[g] = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                check($sformatf("jk m%0d c%0d", g, c), {jv[g], kv[g]}, e.jk);
                check($sformatf("q m%0d c%0d", g, c), qv[g], e.q);
                check($sformatf("mismatch m%0d c%0d", g, c), mm[g], e.mm);
                check($sformatf("done m%0d c%0d", g, c), done[g], e.dn);
                check($sformatf("in_ready m%0d c%0d", g, c), rdy[g], e.rdy);
                check($sformatf("busy m%0d c%0d", g, c), busy[g], !e.rdy);
            end
        end
        check($sformatf("err_count m%0d", g), errc[g], errm[g]);
    endtask

    task automatic reset_models();
        for (int g = 0; g < 3; g++) begin
            mp[g] = 1'b0;
            mq[g] = 1'b0;
            errm[g] = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn_seen;
        in_valid  = '0;
        clear_err = '0;
        force0    = '0;
        for (int g = 0; g < 3; g++) in_data[g] = 8'h00;
        reset_models();

        // asynchronous reset mid-clock
        #3 reset = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            check("reset_jk", {jv[g], kv[g]}, 2'b00);
            check("reset_ready", rdy[g], 1);
            check("reset_err", errc[g], 0);
            check("reset_busy_done_mm", {busy[g], done[g], mm[g]}, 3'b000);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++)
            check("idle_hold", {rdy[g], busy[g], jv[g], kv[g]}, 4'b1000);

        // min-encoding with the flop in the loop
        run_word(0, 8'hA5, 1'b0, 8'h00);
        // toggle encoding
        run_word(1, 8'hF0, 1'b0, 8'h00);

        // force encoding against a stuck-low q, then clear and saturate
        force0[2] = 1'b1;
        run_word(2, 8'h81, 1'b0, 8'h00);
        clear_err[2] = 1'b1;
        @(posedge clk); #1;
        clear_err[2] = 1'b0;
        errm[2] = 0;
        check("clear_err", errc[2], 0);
        for (int n = 0; n < 38; n++) run_word(2, 8'hFF, 1'b0, 8'h00);
        check("err_saturated", errc[2], 255);
        force0[2] = 1'b0;

        // back-to-back words; q_pred carries across
        run_word(0, 8'hFF, 1'b1, 8'h00);
        run_word(0, 8'h00, 1'b0, 8'h00);

        // reset in the middle of a frame
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hFF;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_jk", {jv[0], kv[0]}, 2'b00);
        check("midreset_busy", busy[0], 0);
        check("midreset_done", done[0], 0);
        @(negedge clk);
        reset = 1'b1;
        reset_models();
        dn_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done[0] || busy[0]) dn_seen++;
        end
        check("no_done_after_reset", dn_seen, 0);
        for (int g = 0; g < 3; g++) check("err_after_reset", errc[g], 0);
        run_word(0, 8'hFF, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_excite_tx.md
Name: jk_excite_tx

Overview:
- Transmit end of the JK flip-flop interface: accepts a parallel word and serialises it as a J/K excitation stream, so that a downstream jk_ff reproduces the word bit-by-bit on q.
- Tracks the predicted q internally and checks the actual q fed back from the flip-flop, flagging and counting mismatches.
- Used as a stimulus source and self-checking driver for jk_ff instances in block-level benches and in serial-output datapaths.

Parameters:
- WIDTH, 8, bits per word (2..32).
- ENC_MODE, 0, excitation encoding: 0 = minimal set/reset, 1 = toggle-only, 2 = force (J=d, K=~d).
- LSB_FIRST, 0, 0 = send MSB first, 1 = send LSB first.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_data  in  WIDTH  word to send.
- in_ready  out  1  high only in IDLE; a word is accepted on an edge where in_valid && in_ready.
- j  out  1  registered J excitation to the downstream jk_ff.
- k  out  1  registered K excitation to the downstream jk_ff.
- q_fb  in  1  q of the downstream jk_ff; it shares clk and reset with this block.
- clear_err  in  1  synchronous clear of err_count.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse when the final check of a word completes.
- mismatch  out  1  one-cycle pulse when a q_fb check fails.
- err_count  out  CNT_W  count of mismatches; saturates at all-ones.

Behaviour:
- Reset values (reset low, immediate): state=IDLE, j=0, k=0, in_ready=1, busy=0, done=0, mismatch=0, err_count=0, q_pred=0, check pipeline empty.
- Reset asserted mid-word discards the word immediately; no done pulse is produced for it.
- Timing: E0 is the accept edge. The J/K values for bit i are valid after edge E(i+1). The downstream q equals bit i after E(i+2). q_fb is checked for bit i at E(i+3).
- States:
  - IDLE: j=k=0 (hold). On accept, load the shift register and the bit counter, then go to SHIFT.
  - SHIFT: for each of WIDTH cycles, drive enc(q_pred, d) and set q_pred<=d. After bit WIDTH-1, go to DRAIN.
  - DRAIN: j=k=0 for 2 cycles so the remaining checks complete. At E(WIDTH+2), done=1 for one cycle and state returns to IDLE.
- Frame length: WIDTH+2 cycles after accept; the next word can be accepted at E(WIDTH+3) at the earliest. in_valid is ignored while busy. q_pred persists across words.
- Encoding, with p = q_pred and d = bit to send:
  - Mode 0: 0->0 gives 00; 0->1 gives 10; 1->0 gives 01; 1->1 gives 00.
  - Mode 1: any change gives 11; hold gives 00.
  - Mode 2: J=d, K=~d.
- Check pipeline: the expected bit is delayed 2 stages with a valid flag. On an edge where the flag is set and q_fb differs from the expected bit: mismatch=1 for one cycle, and err_count increments unless already saturated.
- q_pred is never corrected from q_fb, so a wrong prediction in modes 0 and 1 may persist. This is intentional.
- clear_err has priority over an increment on the same edge; a mismatch pulse on that edge is still emitted.
- WIDTH=1: frame is 1 SHIFT cycle plus 2 DRAIN cycles.

Decomposition:
- Package jk_pkg: ENC_MIN, ENC_TOG, ENC_FORCE constants; state encoding (IDLE, SHIFT, DRAIN).
- One combinational sub-module, jk_excite_enc: inputs (p, d), parameter ENC_MODE, outputs (j, k). It is reused by future JK-based counters.
- Top level holds the FSM, shift register, bit counter, q_pred, check pipeline and error counter.

Test Plan:
1. Assert reset low at t=3 mid-clock. Required: j=k=0, in_ready=1, err_count=0 immediately and asynchronously; state holds after release with in_valid=0.
2. ENC_MODE=0, in_data=8'hA5, MSB first, real jk_ff in the loop. Required J/K sequence: 10,01,10,01,00,10,01,10; q sequence: 1,0,1,0,0,1,0,1; no mismatch; done at E10; err_count=0.
3. ENC_MODE=1, 8'hF0 from q_pred=0. Required J/K sequence: 11,00,00,00,11,00,00,00; q sequence: 1,1,1,1,0,0,0,0; no mismatch.
4. ENC_MODE=2, 8'h81, q_fb tied to 0. Required: mismatch pulses at E3 and E10; err_count=2; clear_err -> 0. Forcing 300 mismatches saturates err_count at 255.
5. Back-to-back words 8'hFF then 8'h00 (mode 0), in_valid held high. Required: second word accepted at E11, not earlier; its J/K sequence is 01 then 00 x7, which demonstrates q_pred carries across words.
6. Reset pulsed low after E4 of a frame. Required: j=k=0 and busy=0 immediately; no done pulse; q_pred=0; the next word encodes from p=0.
